// File: rtl/mem_responder.sv
// mem_responder: asynchronous-SRAM style slave with programmable wait states.
// A CPU request (CE low with OE or WE low) is latched in IDLE, optionally
// delayed in WAIT, performed in a single ACCESS cycle, and then held in HOLD
// with R=1 until the CPU raises CE (4-phase handshake).
// Word address 16'hFFFF (low 16 bits) is I/O space: reads return Switches,
// writes update HEX_reg. Every other address indexes the internal array,
// which wraps modulo 2^DEPTH_LOG2.
module mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_LOG2  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] A,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [15:0] Data_in,
  input  logic [15:0] Switches,
  output logic [15:0] Data_out,
  output logic        R,
  output logic [15:0] HEX_reg
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  // The counter holds "remaining wait cycles minus one", so ACCESS is
  // entered on the edge where it reads zero.
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [15:0] IO_ADDR  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Merge new data into an old word, byte lane by byte lane (lanes active-low).
  function automatic logic [15:0] merge_lanes(
    input logic [15:0] old_word,
    input logic [15:0] new_word,
    input logic        ub_n,
    input logic        lb_n
  );
    merge_lanes = {ub_n ? old_word[15:8] : new_word[15:8],
                   lb_n ? old_word[7:0]  : new_word[7:0]};
  endfunction

  // Registered state and its next-state values
  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [19:0] a_q,     a_d;
  logic        ub_q,    ub_d;
  logic        lb_q,    lb_d;
  logic        wr_q,    wr_d;
  logic [15:0] din_q,   din_d;
  logic [15:0] dout_q,  dout_d;
  logic        r_q,     r_d;
  logic [15:0] hex_q,   hex_d;

  // Storage array; deliberately not reset so contents survive Reset.
  logic [15:0] mem_q [0:DEPTH-1];

  // Decoded request and access-time helpers
  logic                  req_s;
  logic                  io_sel_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [15:0]           rd_word_s;
  logic                  mem_we_s;
  logic                  unused_addr_s;

  assign req_s     = ~CE & (~OE | ~WE);
  assign io_sel_s  = (a_q[15:0] == IO_ADDR);
  assign idx_s     = a_q[DEPTH_LOG2-1:0];
  assign rd_word_s = io_sel_s ? Switches : mem_q[idx_s];
  // Array commit happens on the ACCESS exit edge only when not aborted.
  assign mem_we_s  = (state_q == ST_ACCESS) & ~CE & wr_q & ~io_sel_s;
  // The top address nibble is latched but never decoded (aliasing).
  assign unused_addr_s = ^a_q[19:16];

  assign Data_out = dout_q;
  assign R        = r_q;
  assign HEX_reg  = hex_q;

  // Next-state logic for the handshake FSM and its datapath registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    wr_d    = wr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    r_d     = r_q;
    hex_d   = hex_q;

    case (state_q)
      ST_IDLE: begin
        r_d = 1'b0;
        if (req_s) begin
          // Capture everything the access needs so later bus changes are ignored.
          a_d   = A;
          ub_d  = UB;
          lb_d  = LB;
          wr_d  = ~WE;
          din_d = Data_in;
          if (NO_WAIT) begin
            state_d = ST_ACCESS;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (CE) begin
          // CPU withdrew the request: abort without side effects.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ACCESS: begin
        if (CE) begin
          // Abort on the final cycle: no write, Data_out and R untouched.
          state_d = ST_IDLE;
          r_d     = 1'b0;
        end else begin
          if (wr_q) begin
            if (io_sel_s) begin
              hex_d = merge_lanes(hex_q, din_q, ub_q, lb_q);
            end else begin
              hex_d = hex_q;
            end
          end else begin
            dout_d = rd_word_s;
          end
          r_d     = 1'b1;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (CE) begin
          r_d     = 1'b0;
          state_d = ST_IDLE;
        end else begin
          r_d     = 1'b1;
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        r_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 20'h00000;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      wr_q    <= 1'b0;
      din_q   <= 16'h0000;
      dout_q  <= 16'h0000;
      r_q     <= 1'b0;
      hex_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      r_q     <= r_d;
      hex_q   <= hex_d;
    end
  end

  // Array write port; UB=LB=1 rewrites the old word, i.e. no change
  always_ff @(posedge Clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= merge_lanes(mem_q[idx_s], din_q, ub_q, lb_q);
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2: wait cycles inserted before each access (0..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8: internal array holds 2^DEPTH_LOG2 16-bit words.
REQ-003 SHALL have port Clk, input, 1: single rising-edge clock.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port A, input, 20: word address from CPU.
REQ-006 SHALL have ports CE, OE, WE, UB, LB, input, 1 each, all active-low: chip enable, read enable, write enable, upper byte lane [15:8], lower byte lane [7:0].
REQ-007 SHALL have port Data_in, input, 16: CPU write data.
REQ-008 SHALL have port Switches, input, 16: value returned for I/O reads.
REQ-009 SHALL have port Data_out, output, 16: registered read data.
REQ-010 SHALL have port R, output, 1: ready; high = access complete, Data_out valid.
REQ-011 SHALL have port HEX_reg, output, 16: display register, written at I/O address.

Function
REQ-012 SHALL implement FSM with states IDLE, WAIT, ACCESS, HOLD.
REQ-013 A request SHALL be CE=0 with OE=0 or WE=0; WE=0 SHALL take priority (write) when both are low.
REQ-014 In IDLE, on an edge where a request is present, SHALL latch A, UB, LB, the read/write type and Data_in into internal registers.
REQ-015 On that edge SHALL go to ACCESS if WAIT_STATES=0; otherwise SHALL go to WAIT with a 4-bit counter loaded to WAIT_STATES-1.
REQ-016 In WAIT, the counter SHALL decrement each cycle; on the edge where it equals 0, SHALL go to ACCESS.
REQ-017 ACCESS SHALL last exactly one cycle; on its exit edge SHALL commit the write or load Data_out, set R=1, and go to HOLD.
REQ-018 Latency: request sampled at edge n -> R=1 visible after edge n+WAIT_STATES+1.
REQ-019 In HOLD, R and Data_out SHALL hold; on the edge where CE=1, SHALL clear R and go to IDLE (4-phase handshake).
REQ-020 In HOLD, SHALL NOT start a new access until CE has been seen high.
REQ-021 Latched A[15:0]=16'hFFFF SHALL select I/O space: read returns Switches; write updates HEX_reg.
REQ-022 All other addresses SHALL select the array at index A[DEPTH_LOG2-1:0]; upper bits SHALL be ignored (aliasing/wrap).
REQ-023 Writes SHALL honour byte lanes: UB=0 writes [15:8], LB=0 writes [7:0]; UB=LB=1 SHALL change nothing, and R SHALL still assert.
REQ-024 Reads SHALL return the full 16-bit word regardless of UB/LB.
REQ-025 If CE goes high in WAIT or ACCESS, SHALL abort: go to IDLE, perform no write, leave Data_out unchanged, keep R=0.
REQ-026 Changes on A/Data_in after latching SHALL NOT affect the in-flight access.

Reset
REQ-027 Reset=0 SHALL immediately force state=IDLE, R=0, Data_out=16'h0000, HEX_reg=16'h0000, counter=0, including mid-access.
REQ-028 Array contents SHALL NOT be reset; an aborted write SHALL leave the target word unchanged.
REQ-029 After Reset deasserts, the first request SHALL be accepted on the first rising edge.

Verification
REQ-030 Write then read, WAIT_STATES=2: write 16'hBEEF to A=20'h00010 with UB=LB=0, then read A=20'h00010 -> R rises 3 edges after each request; Data_out=16'hBEEF.
REQ-031 Byte lanes: array word 16'h1234; write 16'hABCD with UB=0, LB=1 -> read returns 16'hAB34.
REQ-032 I/O: Switches=16'h5A5A, read A=20'h0FFFF -> Data_out=16'h5A5A; write 16'h00C3 with UB=LB=0 to 20'h0FFFF -> HEX_reg=16'h00C3.
REQ-033 Abort and aliasing: CE raised during WAIT of a write to 20'h00005 -> R stays 0 and a later read shows the old value; with DEPTH_LOG2=8, a read of 20'h00105 returns the word stored at 20'h00005.
REQ-034 Reset mid-HOLD, with R=1 and Data_out=16'hBEEF: assert Reset=0 -> R=0 and Data_out=0 immediately; HEX_reg=0; the next request completes normally.
REQ-035 Handshake and WAIT_STATES=0: hold CE=0 in HOLD for 5 cycles -> no second access; raise CE -> R=0 next edge; with WAIT_STATES=0, R=1 after edge n+1.
